// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared constants and state encoding for the memory arbiter
package mem_arb_pkg;

  // Requester IDs stored in the outstanding-transaction FIFO
  localparam logic ID_IF = 1'b0;
  localparam logic ID_LS = 1'b1;

  // Fetches always read a full word
  localparam logic [3:0] BE_FULL = 4'hF;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mem_arb_id_fifo.sv
// rtl/mem_arb_id_fifo.sv - 1-bit requester ID FIFO for in-order response routing
module mem_arb_id_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic head_id,
  output logic full,
  output logic empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0] ids;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  // Over/underflow is never requested by the arbiter; gate anyway so the count stays sane
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head_id = ids[rd_ptr];

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        ids[wr_ptr] <= push_id;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IF/LS memory port arbiter; MEM_ARB_PERF_EN adds wait-cycle counters
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_OUTST    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [3:0]  ls_be,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        err
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0] perf_if_wait,
  output logic [31:0] perf_ls_wait
`endif
);

  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_t    state;
  logic          sel_lat;
  logic [SW-1:0] starve_cnt;
  logic          starved;
  logic          sel;
  logic          sel_req;
  logic          grant;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_head;

  // IF overrides LS only once it has waited the full limit and still wants the port
  assign starved = (STARVE_LIMIT != 0) && (starve_cnt == STARVE_MAX) && if_req;

  // Selection: a held decision wins; otherwise starvation override, then LS over IF
  always_comb begin
    sel = ID_IF;
    if (state == HOLD) begin
      sel = sel_lat;
    end else if (starved) begin
      sel = ID_IF;
    end else if (ls_req) begin
      sel = ID_LS;
    end
  end

  assign sel_req = (sel == ID_LS) ? ls_req : if_req;

  // A full FIFO blocks new requests even if a response frees a slot this cycle
  assign mem_req   = sel_req & ~fifo_full & ~rst;
  assign grant     = mem_req & mem_gnt;
  assign if_gnt    = grant & (sel == ID_IF);
  assign ls_gnt    = grant & (sel == ID_LS);

  assign mem_we    = (sel == ID_LS) & ls_we;
  assign mem_be    = (sel == ID_LS) ? ls_be    : BE_FULL;
  assign mem_addr  = (sel == ID_LS) ? ls_addr  : if_addr;
  assign mem_wdata = (sel == ID_LS) ? ls_wdata : 32'h0;

  // Responses return in order; the FIFO head says whose response this is
  assign pop       = mem_rvalid & ~fifo_empty & ~rst;
  assign if_rvalid = pop & (fifo_head == ID_IF);
  assign ls_rvalid = pop & (fifo_head == ID_LS);
  assign if_rdata  = mem_rdata;
  assign ls_rdata  = mem_rdata;

  mem_arb_id_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (grant),
    .push_id (sel),
    .pop     (pop),
    .head_id (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Arbitration FSM: latch the selection when it is not accepted immediately
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ARB;
      sel_lat <= ID_IF;
    end else begin
      case (state)
        ARB: begin
          if (sel_req && !grant) begin
            state   <= HOLD;
            sel_lat <= sel;
          end
        end
        HOLD: begin
          if (grant) begin
            state <= ARB;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  // Count LS grants taken while IF is kept waiting; saturates at the limit
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!if_req || if_gnt) begin
      starve_cnt <= '0;
    end else if (ls_gnt && (starve_cnt != STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Sticky error for a response that has no transaction to belong to
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (mem_rvalid && fifo_empty) begin
      err <= 1'b1;
    end
  end

`ifdef MEM_ARB_PERF_EN
  // Wait-cycle counters: a requester waits whenever it asks and is not granted
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_if_wait <= '0;
      perf_ls_wait <= '0;
    end else begin
      if (if_req && !if_gnt) begin
        perf_if_wait <= perf_if_wait + 32'd1;
      end
      if (ls_req && !ls_gnt) begin
        perf_ls_wait <= perf_ls_wait + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter (vector table, directed and random)
module tb_mem_arbiter;

  localparam int MAX_OUTST    = 4;
  localparam int STARVE_LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [3:0]  ls_be;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        err;

  always #5 clk = ~clk;

  mem_arbiter #(
    .MAX_OUTST    (MAX_OUTST),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .ls_req     (ls_req),
    .ls_we      (ls_we),
    .ls_be      (ls_be),
    .ls_addr    (ls_addr),
    .ls_wdata   (ls_wdata),
    .ls_gnt     (ls_gnt),
    .ls_rvalid  (ls_rvalid),
    .ls_rdata   (ls_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .err        (err)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: a queue of issuer IDs, an optional pending decision, a wait count
  int   m_q[$];
  int   m_lock = -1;
  int   m_wait = 0;
  bit   m_err  = 1'b0;
  int   m_ch;
  bit   m_sel_req;
  bit   e_if_gnt, e_ls_gnt, e_mem_req, e_if_rv, e_ls_rv, e_err, e_we;
  logic [3:0]  e_be;
  logic [31:0] e_addr, e_wdata;

  // Values sampled from the DUT on the falling edge of the last cycle
  logic        s_if_gnt, s_ls_gnt, s_mem_req, s_if_rv, s_ls_rv, s_err;
  logic [31:0] s_mem_addr;

  typedef struct packed {
    bit rst, if_req, ls_req, mem_gnt, mem_rvalid;
    bit x_if_gnt, x_ls_gnt, x_mem_req, x_if_rv, x_ls_rv, x_err;
  } vec_t;

  vec_t tbl[19];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_eval();
    e_err = m_err;
    if (rst) begin
      {e_if_gnt, e_ls_gnt, e_mem_req, e_if_rv, e_ls_rv} = '0;
      m_ch = 0; m_sel_req = 1'b0; e_we = 1'b0;
      e_be = 4'hF; e_addr = '0; e_wdata = '0;
    end else begin
      if (m_lock >= 0)                                               m_ch = m_lock;
      else if (STARVE_LIMIT > 0 && m_wait >= STARVE_LIMIT && if_req) m_ch = 0;
      else if (ls_req)                                               m_ch = 1;
      else                                                           m_ch = 0;
      m_sel_req = (m_ch == 1) ? ls_req : if_req;
      e_mem_req = m_sel_req && (m_q.size() < MAX_OUTST);
      e_if_gnt  = e_mem_req && mem_gnt && (m_ch == 0);
      e_ls_gnt  = e_mem_req && mem_gnt && (m_ch == 1);
      e_addr    = (m_ch == 1) ? ls_addr  : if_addr;
      e_we      = (m_ch == 1) ? ls_we    : 1'b0;
      e_be      = (m_ch == 1) ? ls_be    : 4'hF;
      e_wdata   = (m_ch == 1) ? ls_wdata : 32'h0;
      e_if_rv   = mem_rvalid && (m_q.size() > 0) && (m_q[0] == 0);
      e_ls_rv   = mem_rvalid && (m_q.size() > 0) && (m_q[0] == 1);
    end
  endtask

  task automatic model_commit();
    if (rst) begin
      m_q.delete();
      m_lock = -1;
      m_wait = 0;
      m_err  = 1'b0;
    end else begin
      if (mem_rvalid) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        else m_err = 1'b1;
      end
      if (e_if_gnt || e_ls_gnt) m_q.push_back(m_ch);
      m_lock = (e_if_gnt || e_ls_gnt) ? -1 : (m_sel_req ? m_ch : -1);
      if (!if_req || e_if_gnt) m_wait = 0;
      else if (e_ls_gnt && m_wait < STARVE_LIMIT) m_wait++;
    end
  endtask

  // One clock: model predicts, DUT sampled on the falling edge, state advances on the rising edge
  task automatic cycle();
    model_eval();
    @(negedge clk);
    s_if_gnt = if_gnt; s_ls_gnt = ls_gnt; s_mem_req = mem_req;
    s_if_rv = if_rvalid; s_ls_rv = ls_rvalid; s_err = err; s_mem_addr = mem_addr;
    chk1("m_if_gnt", if_gnt, e_if_gnt);
    chk1("m_ls_gnt", ls_gnt, e_ls_gnt);
    chk1("m_mem_req", mem_req, e_mem_req);
    chk1("m_if_rvalid", if_rvalid, e_if_rv);
    chk1("m_ls_rvalid", ls_rvalid, e_ls_rv);
    chk1("m_err", err, e_err);
    if (e_mem_req) begin
      chk32("m_mem_addr", mem_addr, e_addr);
      chk1("m_mem_we", mem_we, e_we);
      chk32("m_mem_be", {28'h0, mem_be}, {28'h0, e_be});
      chk32("m_mem_wdata", mem_wdata, e_wdata);
    end
    if (e_if_rv) chk32("m_if_rdata", if_rdata, mem_rdata);
    if (e_ls_rv) chk32("m_ls_rdata", ls_rdata, mem_rdata);
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic apply_row(input int i);
    rst = tbl[i].rst; if_req = tbl[i].if_req; ls_req = tbl[i].ls_req;
    mem_gnt = tbl[i].mem_gnt; mem_rvalid = tbl[i].mem_rvalid;
    if_addr = 32'h0000_0100; ls_addr = 32'h0000_1000;
    ls_we = 1'b1; ls_be = 4'h3; ls_wdata = 32'hA5A5_0000 + i;
    mem_rdata = $urandom;
    cycle();
    chk1($sformatf("row%0d_if_gnt", i), s_if_gnt, tbl[i].x_if_gnt);
    chk1($sformatf("row%0d_ls_gnt", i), s_ls_gnt, tbl[i].x_ls_gnt);
    chk1($sformatf("row%0d_mem_req", i), s_mem_req, tbl[i].x_mem_req);
    chk1($sformatf("row%0d_if_rvalid", i), s_if_rv, tbl[i].x_if_rv);
    chk1($sformatf("row%0d_ls_rvalid", i), s_ls_rv, tbl[i].x_ls_rv);
    chk1($sformatf("row%0d_err", i), s_err, tbl[i].x_err);
  endtask

  initial begin
    int found;

    //                rst if ls gnt rv   ifg lsg mreq ifrv lsrv err
    tbl[0]  = 11'b1_0_0_0_0__0_0_0_0_0_0;   // reset state
    tbl[1]  = 11'b0_1_1_1_0__0_1_1_0_0_0;   // both request: LS first
    tbl[2]  = 11'b0_1_0_1_1__1_0_1_0_1_0;   // IF next; LS response
    tbl[3]  = 11'b0_0_0_0_1__0_0_0_1_0_0;   // IF response
    tbl[4]  = 11'b0_0_1_1_0__0_1_1_0_0_0;   // fill FIFO
    tbl[5]  = 11'b0_0_1_1_0__0_1_1_0_0_0;
    tbl[6]  = 11'b0_0_1_1_0__0_1_1_0_0_0;
    tbl[7]  = 11'b0_0_1_1_0__0_1_1_0_0_0;
    tbl[8]  = 11'b0_0_1_1_0__0_0_0_0_0_0;   // full: no request
    tbl[9]  = 11'b0_0_1_1_1__0_0_0_0_1_0;   // full blocks despite pop
    tbl[10] = 11'b0_0_1_1_0__0_1_1_0_0_0;   // slot freed: granted
    tbl[11] = 11'b0_0_0_0_1__0_0_0_0_1_0;   // drain
    tbl[12] = 11'b0_0_0_0_1__0_0_0_0_1_0;
    tbl[13] = 11'b0_0_0_0_1__0_0_0_0_1_0;
    tbl[14] = 11'b0_0_0_0_1__0_0_0_0_1_0;
    tbl[15] = 11'b0_0_0_0_1__0_0_0_0_0_0;   // spurious response
    tbl[16] = 11'b0_0_0_0_0__0_0_0_0_0_1;   // err is sticky
    tbl[17] = 11'b1_0_0_0_0__0_0_0_0_0_1;   // still set during reset cycle
    tbl[18] = 11'b0_0_0_0_0__0_0_0_0_0_0;   // cleared by reset

    rst = 1'b1; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0;
    ls_be = '0; ls_addr = '0; ls_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    @(posedge clk);
    model_commit();
    #1;

    for (int i = 0; i < 19; i++) apply_row(i);

    // IF stalled by memory while LS arrives: IF decision and address held
    rst = 1'b0; if_req = 1'b1; if_addr = 32'h0000_0400; ls_req = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    cycle();
    chk32("s2_addr_c0", s_mem_addr, 32'h0000_0400);
    ls_req = 1'b1; ls_addr = 32'h0000_2000; ls_we = 1'b0; ls_be = 4'hF;
    for (int k = 1; k < 3; k++) begin
      cycle();
      chk32($sformatf("s2_addr_c%0d", k), s_mem_addr, 32'h0000_0400);
      chk1($sformatf("s2_ls_gnt_c%0d", k), s_ls_gnt, 1'b0);
    end
    mem_gnt = 1'b1;
    cycle();
    chk1("s2_if_gnt", s_if_gnt, 1'b1);
    if_req = 1'b0;
    cycle();
    chk1("s2_ls_gnt", s_ls_gnt, 1'b1);
    chk32("s2_ls_addr", s_mem_addr, 32'h0000_2000);
    ls_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    cycle();
    chk1("s2_if_rvalid", s_if_rv, 1'b1);
    cycle();
    chk1("s2_ls_rvalid", s_ls_rv, 1'b1);
    mem_rvalid = 1'b0;

    // Starvation: continuous LS traffic must still let IF in
    if_req = 1'b1; if_addr = 32'h0000_0800; ls_req = 1'b1; mem_gnt = 1'b1;
    found = -1;
    for (int k = 0; k < 20; k++) begin
      mem_rvalid = (m_q.size() > 0); mem_rdata = $urandom;
      cycle();
      if (s_if_gnt === 1'b1) begin
        found = k;
        break;
      end
    end
    chk1("s3_if_gnt_by_9th_cycle", (found >= 0) && (found <= 8), 1'b1);
    if_req = 1'b0; ls_req = 1'b0; mem_gnt = 1'b0;
    for (int k = 0; k < 8 && m_q.size() > 0; k++) begin
      mem_rvalid = 1'b1;
      cycle();
    end
    mem_rvalid = 1'b0;

    // Reset with two transactions in flight, response in the reset cycle ignored
    ls_req = 1'b1; mem_gnt = 1'b1;
    cycle();
    cycle();
    ls_req = 1'b0; mem_gnt = 1'b0;
    rst = 1'b1; mem_rvalid = 1'b1;
    cycle();
    chk1("s6_rst_mem_req", s_mem_req, 1'b0);
    chk1("s6_rst_if_rvalid", s_if_rv, 1'b0);
    chk1("s6_rst_ls_rvalid", s_ls_rv, 1'b0);
    rst = 1'b0; mem_rvalid = 1'b0;
    cycle();
    chk1("s6_post_mem_req", s_mem_req, 1'b0);
    chk1("s6_post_err", s_err, 1'b0);
    for (int i = 1; i < 4; i++) apply_row(i);
    mem_rvalid = 1'b0; if_req = 1'b0; ls_req = 1'b0;
    cycle();
    chk1("s6_final_err", s_err, 1'b0);

    // Randomized traffic against the model; requesters obey hold-until-grant
    if_req = 1'b0; ls_req = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!ls_req && $urandom_range(0, 3) != 0) begin
        ls_req = 1'b1; ls_we = 1'($urandom); ls_be = 4'($urandom);
        ls_addr = $urandom; ls_wdata = $urandom;
      end
      mem_gnt    = ($urandom_range(0, 3) != 0);
      mem_rvalid = (m_q.size() > 0) && ($urandom_range(0, 2) == 0);
      mem_rdata  = $urandom;
      rst        = ($urandom_range(0, 199) == 0);
      cycle();
      if (e_if_gnt || rst) if_req = 1'b0;
      if (e_ls_gnt || rst) ls_req = 1'b0;
      rst = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
